// File: rtl/cp0_pkg.sv
// cp0_pkg: CP0 register indices, Status/Cause field positions and exception codes.
package cp0_pkg;
  localparam int CP0_COUNT   = 9;
  localparam int CP0_COMPARE = 11;
  localparam int CP0_STATUS  = 12;
  localparam int CP0_CAUSE   = 13;
  localparam int CP0_EPC     = 14;
  localparam int ST_IE   = 0;
  localparam int ST_EXL  = 1;
  localparam int ST_IM   = 8;
  localparam int CA_CODE = 2;
  localparam int CA_IP   = 8;
  localparam int CA_TI   = 30;
  typedef enum logic [4:0] {
    EXC_INT = 5'd0,
    EXC_SYS = 5'd8,
    EXC_RI  = 5'd10,
    EXC_OV  = 5'd12
  } exc_code_e;
endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: free-running Count, Compare and sticky timer-interrupt flag (built with CP0_TIMER_EN).
module cp0_timer
  import cp0_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int AW     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     Wt_addr,
  input  logic [DATA_W-1:0] Wt_data,
  output logic [DATA_W-1:0] count,
  output logic [DATA_W-1:0] compare,
  output logic              ti
);
  logic              wr_cmp;
  logic [DATA_W-1:0] count_nx;
  assign wr_cmp   = we && Wt_addr == AW'(CP0_COMPARE);
  assign count_nx = (we && Wt_addr == AW'(CP0_COUNT)) ? Wt_data : count + 1'b1;
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      compare <= '0;
      ti      <= 1'b0;
    end else begin
      count <= count_nx;
      if (wr_cmp) compare <= Wt_data;
      ti <= wr_cmp ? 1'b0 : (ti | (count_nx == compare));
    end
  end
endmodule

// File: rtl/cp0_exc_unit.sv
// cp0_exc_unit: CP0 register file with exception/interrupt entry and ERET sequencing.
// Define CP0_TIMER_EN to build the Count/Compare timer interrupt.
module cp0_exc_unit
  import cp0_pkg::*;
#(
  parameter int                 DATA_W     = 32,
  parameter int                 NREG       = 32,
  parameter int                 NIRQ       = 6,
  parameter logic [DATA_W-1:0]  EXC_VECTOR = DATA_W'(32'h0000_0180),
  localparam int                AW         = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     R_addr,
  input  logic [AW-1:0]     Wt_addr,
  input  logic [DATA_W-1:0] Wt_data,
  output logic [DATA_W-1:0] rdata,
  input  logic [NIRQ-1:0]   irq_in,
  input  logic              exc_req,
  input  logic [4:0]        exc_code,
  input  logic [DATA_W-1:0] exc_pc,
  input  logic              eret,
  output logic              exc_take,
  output logic [DATA_W-1:0] vector_out,
  output logic [DATA_W-1:0] epc_out,
  output logic              int_pending
);
  localparam int TI_BIT = DATA_W >= 32 ? CA_TI : DATA_W - 2;
  logic [DATA_W-1:0] gp [NREG];
  logic              ie, exl, ti;
  logic [NIRQ-1:0]   im, ip;
  logic [4:0]        code, code_sel;
  logic [DATA_W-1:0] epc, count, compare, status_rd, cause_rd;
  logic              wr_status, wr_epc;
`ifdef CP0_TIMER_EN
  cp0_timer #(.DATA_W(DATA_W), .AW(AW)) u_timer (
    .clk(clk), .rst(rst), .we(we), .Wt_addr(Wt_addr), .Wt_data(Wt_data),
    .count(count), .compare(compare), .ti(ti)
  );
`else
  assign count   = gp[CP0_COUNT];
  assign compare = gp[CP0_COMPARE];
  assign ti      = 1'b0;
`endif
  assign wr_status   = we && Wt_addr == AW'(CP0_STATUS);
  assign wr_epc      = we && Wt_addr == AW'(CP0_EPC);
  assign int_pending = |(ip & im) | (ti & im[NIRQ-1]);
  assign exc_take    = exc_req | (ie & ~exl & int_pending);
  assign code_sel    = exc_req ? exc_code : EXC_INT;
  assign vector_out  = EXC_VECTOR;
  assign epc_out     = epc;
  always_comb begin
    status_rd = '0;
    status_rd[ST_IE] = ie;
    status_rd[ST_EXL] = exl;
    status_rd[ST_IM +: NIRQ] = im;
    cause_rd = '0;
    cause_rd[CA_CODE +: 5] = code;
    cause_rd[CA_IP +: NIRQ] = ip;
    cause_rd[TI_BIT] = ti;
    rdata = R_addr == AW'(CP0_STATUS)  ? status_rd :
            R_addr == AW'(CP0_CAUSE)   ? cause_rd  :
            R_addr == AW'(CP0_EPC)     ? epc       :
            R_addr == AW'(CP0_COUNT)   ? count     :
            R_addr == AW'(CP0_COMPARE) ? compare   : gp[R_addr];
  end
  // Trap field updates are applied last so they override a concurrent mtc0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) gp[i] <= '0;
      ie   <= 1'b0;
      exl  <= 1'b0;
      im   <= '0;
      ip   <= '0;
      code <= '0;
      epc  <= '0;
    end else begin
      if (we) gp[Wt_addr] <= Wt_data;
      ip <= irq_in;
      if (wr_status) begin
        ie  <= Wt_data[ST_IE];
        exl <= Wt_data[ST_EXL];
        im  <= Wt_data[ST_IM +: NIRQ];
      end
      if (wr_epc) epc <= Wt_data;
      if (exc_take) begin
        code <= code_sel;
        if (!exl) begin
          epc <= exc_pc;
          exl <= 1'b1;
        end
      end else if (eret && exl) exl <= 1'b0;
    end
  end
endmodule

// File: doc/cp0_exc_unit.md
Name: cp0_exc_unit

Overview:
Parametrised coprocessor-0 successor for the AAI_CPU pipeline. It provides a CP0 register file with read/write access through mtc0/mfc0, together with architected Status, Cause, EPC, Count and Compare registers. It also implements an exception/interrupt entry and ERET return sequencer. The block sits beside the ID/EX stage, and its take/vector/EPC outputs drive the PC-select and flush logic.

Parameters:
DATA_W, 32, register width; must be at least 16.
NREG, 32, number of CP0 registers; must be a power of two and at least 16. Address width AW = $clog2(NREG).
NIRQ, 6, number of external interrupt lines; range 1..8.
EXC_VECTOR, 32'h0000_0180, handler entry address, truncated to DATA_W.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
we  in  1  software (mtc0) write enable.
R_addr  in  AW  read address.
Wt_addr  in  AW  write address.
Wt_data  in  DATA_W  write data.
rdata  out  DATA_W  combinational read of register[R_addr].
irq_in  in  NIRQ  level-sensitive external interrupts.
exc_req  in  1  synchronous exception request from the pipeline.
exc_code  in  5  ExcCode for exc_req.
exc_pc  in  DATA_W  PC of the faulting or interrupted instruction.
eret  in  1  ERET executing.
exc_take  out  1  combinational; trap is taken this cycle, so flush and redirect.
vector_out  out  DATA_W  constant EXC_VECTOR.
epc_out  out  DATA_W  current EPC value, used as the ERET target.
int_pending  out  1  combinational; high when (IP & IM) != 0.

Behaviour:
- Register map:
  - 9 = Count.
  - 11 = Compare.
  - 12 = Status: bit0 IE, bit1 EXL, bits[8+NIRQ-1:8] IM; all other bits read as 0.
  - 13 = Cause: bits[6:2] ExcCode, bits[8+NIRQ-1:8] IP; read-only, software writes are ignored.
  - 14 = EPC.
  - All other indices are plain storage.
- Reset: every register clears to 0 on the first clk edge with rst=1, so EXL=0 and IE=0. exc_take=0, int_pending=0, and epc_out=0 after reset. Reset wins over every concurrent event, including mid-trap.
- IP update: IP <= irq_in every cycle, giving a one-cycle registered latency. The timer bit is described under Optional Feature.
- Interrupt condition: int_cond = IE & ~EXL & int_pending.
- Trap taking:
  - exc_take = exc_req | int_cond.
  - exc_req has priority; for an interrupt trap, ExcCode = 0.
- On the exc_take edge:
  - Cause.ExcCode is written with the selected code.
  - If EXL was 0, EPC <= exc_pc and EXL <= 1.
  - If EXL was already 1 (nested synchronous exception), EPC is held and ExcCode is still updated.
- Sequencer states (encoded by EXL):
  - NORMAL -> TRAP on exc_take.
  - TRAP -> NORMAL on eret, which sets EXL <= 0.
  - eret in NORMAL is a no-op.
  - eret together with exc_req in the same cycle: the exception wins and eret is ignored.
- Software write collisions: when we=1 in the same cycle as a trap, the trap's field updates (EXL, ExcCode, EPC) override the write. A software write to any other register or field still lands.
- Read-after-write: no bypass. rdata shows new data the cycle after the write.
- Addresses are always in range. NREG as a power of two guarantees there is no wrap issue.

Optional Feature:
CP0_TIMER_EN.
- Defined:
  - Count increments by 1 every cycle, wrapping modulo 2^DATA_W. A software write to Count takes precedence over the increment.
  - When Count == Compare (evaluated after the increment), the sticky bit TI (Cause bit 30, or DATA_W-2 if DATA_W < 32) sets.
  - Any write to Compare clears TI; clearing wins over setting in the same cycle.
  - TI is ORed into int_pending, gated by IM[NIRQ-1].
- Undefined: Count and Compare are plain storage, TI reads as 0, and no timer logic is synthesised.

Decomposition:
- Package cp0_pkg holds:
  - register index constants: CP0_COUNT, CP0_COMPARE, CP0_STATUS, CP0_CAUSE, CP0_EPC;
  - Status/Cause bit-position constants;
  - ExcCode constants: EXC_INT=0, EXC_SYS=8, EXC_RI=10, EXC_OV=12.
- One natural sub-module, cp0_timer, holds Count, Compare, TI and the compare logic. It is instantiated only under CP0_TIMER_EN.

Test Plan:
1. rst=1 for one edge after arbitrary writes -> rdata=0 at every address; exc_take=0; Status=0.
2. Write Status=32'h0000_0101 (IE=1, IM0=1), then irq_in[0]=1 -> int_pending goes high on the next cycle; exc_take=1 with exc_pc=32'h0000_0040 -> EPC=0x40, Cause.ExcCode=0, EXL=1, and exc_take=0 thereafter.
3. exc_req=1, exc_code=8, exc_pc=0x100, then a second exc_req with exc_code=12, exc_pc=0x200 while EXL=1 -> EPC stays 0x100 and ExcCode=12.
4. eret with EXL=1 -> EXL=0 next cycle and epc_out=0x100. eret together with exc_req -> EXL stays 1 and EPC is updated.
5. Same-cycle mtc0 to EPC (0xDEAD) and exc_req with exc_pc=0x300 -> EPC=0x300. mtc0 to reg 5 in the same cycle -> reg 5 is written.
6. With CP0_TIMER_EN: write Compare=10 and Count=0 -> TI sets after 10 cycles; with IM5=1 and IE=1, exc_take=1. A Compare write clears TI.
